// File: rtl/decrypt.sv
// decrypt: iterative AES-128 decryptor, key expansion then one inverse round per enabled cycle.
// Optional macro KEY_CACHE_EN skips key expansion when the same key is presented again.
module decrypt #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          start,
    input  logic [KW-1:0] cyphertext,
    input  logic [KW-1:0] initial_key,
    output logic [KW-1:0] plaintext,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE = 2'd0, KEYEXP = 2'd1, ROUND = 2'd2} fsm_t;

    fsm_t          fsm_r;
    logic [3:0]    cnt_r;
    logic [KW-1:0] state_r;
    logic [KW-1:0] rk_r [0:NR];
    logic [3:0]    key_idx_s;
    logic [KW-1:0] key_next_s;
    logic [KW-1:0] sub_s;
    logic [KW-1:0] add_s;
    logic [KW-1:0] mix_s;
`ifdef KEY_CACHE_EN
    logic [KW-1:0] last_key_r;
    logic          key_valid_r;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (2+4+...+128); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3r, t, n0, n1, n2, n3;
        w3r = {k[23:0], k[31:24]};
        t   = {sbox(w3r[31:24]) ^ rc, sbox(w3r[23:16]), sbox(w3r[15:8]), sbox(w3r[7:0])};
        n0  = k[127:96] ^ t;
        n1  = k[95:64] ^ n0;
        n2  = k[63:32] ^ n1;
        n3  = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte 4c+r is row r of column c; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Next round key and inverse-round datapath from the current counter.
    always_comb begin
        key_idx_s = 4'd0;
        if (cnt_r != 4'd0) key_idx_s = cnt_r - 4'd1;
        else               key_idx_s = 4'd0;
        key_next_s = expand_key(rk_r[key_idx_s], rcon(cnt_r));
        sub_s      = inv_sub_bytes(inv_shift_rows(state_r));
        add_s      = sub_s ^ rk_r[cnt_r];
        mix_s      = inv_mix_columns(add_s);
    end

    // Control FSM, round-key storage and result registers; en=0 freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_r     <= IDLE;
            cnt_r     <= 4'd0;
            state_r   <= '0;
            plaintext <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i <= NR; i++) rk_r[i] <= '0;
`ifdef KEY_CACHE_EN
            last_key_r  <= '0;
            key_valid_r <= 1'b0;
`endif
        end else if (en) begin
            done <= 1'b0;
            case (fsm_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= cyphertext;
                        rk_r[0]  <= initial_key;
                        busy     <= 1'b1;
`ifdef KEY_CACHE_EN
                        if (key_valid_r && (initial_key == last_key_r)) begin
                            fsm_r <= ROUND;
                            cnt_r <= 4'(NR);
                        end else begin
                            fsm_r <= KEYEXP;
                            cnt_r <= 4'd1;
                        end
`else
                        fsm_r <= KEYEXP;
                        cnt_r <= 4'd1;
`endif
                    end
                end
                KEYEXP: begin
                    rk_r[cnt_r] <= key_next_s;
                    if (cnt_r == 4'(NR)) begin
                        fsm_r <= ROUND;
`ifdef KEY_CACHE_EN
                        key_valid_r <= 1'b1;
                        last_key_r  <= rk_r[0];
`endif
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ROUND: begin
                    if (cnt_r == 4'(NR)) begin
                        state_r <= state_r ^ rk_r[cnt_r];
                        cnt_r   <= cnt_r - 4'd1;
                    end else if (cnt_r != 4'd0) begin
                        state_r <= mix_s;
                        cnt_r   <= cnt_r - 4'd1;
                    end else begin
                        state_r   <= add_s;
                        plaintext <= add_s;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        fsm_r     <= IDLE;
                    end
                end
                default: fsm_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decrypt.sv
// tb_decrypt: scoreboard bench for the AES-128 decryptor; stimulus pushes expected results, a monitor checks each done.
// Honors KEY_CACHE_EN for the cache-hit latency.
module tb_decrypt;

    logic         clk = 1'b0;
    logic         reset, en, start;
    logic [127:0] cyphertext, initial_key;
    logic [127:0] plaintext;
    logic         busy, done;

`ifdef KEY_CACHE_EN
    localparam int HIT_LAT = 11;
`else
    localparam int HIT_LAT = 21;
`endif

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_R = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] PT_R  = 128'h9a5a13e28d1cba92bbbbfb4aaa88095f;

    decrypt dut (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .cyphertext(cyphertext), .initial_key(initial_key),
        .plaintext(plaintext), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] pt;
        int           due;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ---------------- reference encryptor (only used to build the round-trip vector)
    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = m_xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv, r, y;
        inv = 8'h00;
        for (int k = 1; k < 256; k++) if (m_mul(x, 8'(k)) == 8'h01) inv = 8'(k);
        r = inv;
        y = inv ^ 8'h63;
        for (int k = 1; k <= 4; k++) begin
            r = {r[6:0], r[7]};
            y ^= r;
        end
        return y;
    endfunction

    function automatic logic [127:0] m_next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w[4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {m_sbox(w[3][23:16]) ^ rc, m_sbox(w[3][15:8]), m_sbox(w[3][7:0]), m_sbox(w[3][31:24])};
        w[0] ^= t;
        w[1] ^= w[0];
        w[2] ^= w[1];
        w[3] ^= w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   b[16];
        logic [7:0]   t[16];
        logic [127:0] k, s;
        logic [7:0]   rc;
        k  = key;
        s  = pt ^ key;
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) b[i] = m_sbox(s[127-8*i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    b[4*c]   = m_mul(t[4*c], 8'h02) ^ m_mul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    b[4*c+1] = t[4*c] ^ m_mul(t[4*c+1], 8'h02) ^ m_mul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    b[4*c+2] = t[4*c] ^ t[4*c+1] ^ m_mul(t[4*c+2], 8'h02) ^ m_mul(t[4*c+3], 8'h03);
                    b[4*c+3] = m_mul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ m_mul(t[4*c+3], 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) b[i] = t[i];
            end
            k  = m_next_key(k, rc);
            rc = m_xt(rc);
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = b[i];
            s ^= k;
        end
        return s;
    endfunction

    // ---------------- monitor: every done pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done seen at cycle %0d, required no done", cyc);
            end else begin
                e = sb_q.pop_front();
                check({e.name, " plaintext"}, plaintext, e.pt);
                check({e.name, " done_cycle"}, 128'(cyc), 128'(e.due));
                check({e.name, " busy_at_done"}, {127'd0, busy}, 128'd0);
            end
        end
    end

    task automatic issue(input string name, input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] pt, input int lat, input bit expect_done, output int acc);
        @(negedge clk);
        initial_key = key;
        cyphertext  = ct;
        start       = 1'b1;
        @(negedge clk);
        acc         = cyc;
        start       = 1'b0;
        cyphertext  = ~ct;
        initial_key = ~key;
        if (expect_done) sb_q.push_back('{pt, acc + lat, name});
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: %0d results pending after %0d cycles, required 0", sb_q.size(), budget);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           acc, acc2, k;
        bit           all_busy;
        logic [127:0] ct_r;

        reset = 1'b1; en = 1'b1; start = 1'b0;
        cyphertext = '0; initial_key = '0;
        repeat (3) @(negedge clk);
        check("reset plaintext", plaintext, 128'd0);
        check("reset busy", {127'd0, busy}, 128'd0);
        check("reset done", {127'd0, done}, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Test 1: FIPS-197 appendix B, busy held through the operation.
        issue("t1_fips_b", KEY_B, CT_B, PT_B, 21, 1'b1, acc);
        all_busy = busy;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            all_busy &= busy;
        end
        check("t1 busy_throughout", {127'd0, all_busy}, 128'd1);
        wait_drain(40);

        // Test 2: FIPS-197 C.1.
        issue("t2_fips_c1", KEY_C, CT_C, PT_C, 21, 1'b1, acc);
        wait_drain(40);

        // Test 3: round trip through the reference encryptor.
        ct_r = m_encrypt(PT_R, KEY_R);
        issue("t3_roundtrip", KEY_R, ct_r, PT_R, 21, 1'b1, acc);
        wait_drain(40);

        // Test 4: start pulse while busy, then en low for 5 cycles at round 4.
        issue("t4_stall", KEY_B, CT_B, PT_B, 26, 1'b1, acc);
        while (cyc < acc + 4) @(negedge clk);
        initial_key = KEY_C; cyphertext = CT_C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < acc + 14) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        wait_drain(40);
        repeat (30) @(negedge clk);

        // Test 5: reset during key expansion, then a clean run.
        issue("t5_abort", KEY_C, CT_C, PT_C, 21, 1'b0, acc);
        while (cyc < acc + 7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5 reset plaintext", plaintext, 128'd0);
        check("t5 reset busy", {127'd0, busy}, 128'd0);
        check("t5 reset done", {127'd0, done}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        issue("t5_after_reset", KEY_C, CT_C, PT_C, 21, 1'b1, acc);
        wait_drain(40);

        // Test 6: start held high for back-to-back blocks with the same key, then a new key.
        @(negedge clk);
        initial_key = KEY_B; cyphertext = CT_B; start = 1'b1;
        @(negedge clk);
        acc = cyc;
        sb_q.push_back('{PT_B, acc + 21, "t6_first"});
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        acc2  = cyc;
        start = 1'b0;
        sb_q.push_back('{PT_B, acc2 + HIT_LAT, "t6_same_key"});
        wait_drain(40);
        issue("t6_new_key", KEY_C, CT_C, PT_C, 21, 1'b1, acc);
        wait_drain(40);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
